serial_register_receiver: RTL and testbench

- Receive-end counterpart of the display/diagnostic serial shift-register link driven by the MCOI XU5 system. That link uses three lines: shift clock, data and latch, in the 74HC595 style.
- Oversamples the three lines in the system clock domain and deserialises them into a parallel word. Checks frame length and timing.
- Used on the loopback/diag path and in system-level benches to read back what the system pushed to the display hardware.

---
 rtl/serial_register_receiver.sv | 229 ++++++++++++++++++++++
 tb/tb_serial_register_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_register_receiver.sv
// serial_register_receiver
// Receive side of a three-line (shift clock / data / latch) 74HC595-style
// serial link. The lines are oversampled in the system clock domain and the
// frame is deserialised MSB first into a parallel word. Frames with the wrong
// length, or that stall mid-frame, are reported and counted.

package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

module serial_register_receiver #(
  parameter int g_width       = 32,
  parameter int g_sync_stages = 2,
  parameter int g_timeout     = 1000
) (
  input  ckrs_pkg::ckrs_t      ClkRs_ix,
  input  logic                 SerClk_i,
  input  logic                 SerData_i,
  input  logic                 SerLatch_i,
  output logic [g_width-1:0]   Data_ob,
  output logic                 DataValid_o,
  output logic                 FrameError_o,
  output logic [15:0]          ErrorCount_ob,
  output logic                 Busy_o
);

  localparam int CW = $clog2(g_width + 1);
  localparam int TW = (g_timeout > 1) ? $clog2(g_timeout) : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(g_width);
  localparam logic [TW-1:0] TMO_ZERO = TW'(0);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(g_timeout - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic clk;
  logic rst_n;
  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.reset;

  // Input synchronisers and registered edge detection
  logic [g_sync_stages-1:0] sclk_sync_q;
  logic [g_sync_stages-1:0] sdat_sync_q;
  logic [g_sync_stages-1:0] slat_sync_q;
  logic                     sclk_prev_q;
  logic                     slat_prev_q;
  logic                     sclk_rise_q;
  logic                     slat_rise_q;
  logic                     sdat_bit_q;

  // Frame state
  logic [0:0]         state_q,  state_d;
  logic [g_width-1:0] shift_q,  shift_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [TW-1:0]      tmo_q,    tmo_d;
  logic               ovf_q,    ovf_d;
  logic [g_width-1:0] data_q,   data_d;
  logic               valid_q,  valid_d;
  logic               err_q,    err_d;
  logic [15:0]        errcnt_q, errcnt_d;
  logic               busy_q;

  logic [g_width-1:0] shift_in_s;
  logic [CW-1:0]      cnt_inc_s;

  // The data bit is captured alongside the rise pulse so both refer to the
  // same sampled instant.
  assign shift_in_s = {shift_q[g_width-2:0], sdat_bit_q};
  assign cnt_inc_s  = cnt_q + CNT_ONE;

  // Synchronise the three serial lines and register their rising edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sdat_sync_q <= '0;
      slat_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      slat_prev_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      slat_rise_q <= 1'b0;
      sdat_bit_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[g_sync_stages-2:0], SerClk_i};
      sdat_sync_q <= {sdat_sync_q[g_sync_stages-2:0], SerData_i};
      slat_sync_q <= {slat_sync_q[g_sync_stages-2:0], SerLatch_i};
      sclk_prev_q <= sclk_sync_q[g_sync_stages-1];
      slat_prev_q <= slat_sync_q[g_sync_stages-1];
      sclk_rise_q <= sclk_sync_q[g_sync_stages-1] & ~sclk_prev_q;
      slat_rise_q <= slat_sync_q[g_sync_stages-1] & ~slat_prev_q;
      sdat_bit_q  <= sdat_sync_q[g_sync_stages-1];
    end
  end

  // Frame FSM: shift bits, commit on latch, abort on overflow/short/stall
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = TMO_ZERO;
        if (slat_rise_q) begin
          if (ovf_q) begin
            // Latch closing an overflowed frame was already counted.
            ovf_d = 1'b0;
          end else if (sclk_rise_q) begin
            // One bit shifted then latched: can never be a full frame.
            shift_d = shift_in_s;
            err_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          cnt_d = CNT_ZERO;
        end else if (sclk_rise_q && !ovf_q) begin
          shift_d = shift_in_s;
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      SHIFT: begin
        if (sclk_rise_q && (cnt_q == CNT_FULL)) begin
          // Overflow; a coincident latch closes the frame immediately.
          err_d   = 1'b1;
          ovf_d   = ~slat_rise_q;
          cnt_d   = CNT_ZERO;
          tmo_d   = TMO_ZERO;
          state_d = IDLE;
        end else if (sclk_rise_q) begin
          tmo_d = TMO_ZERO;
          if (slat_rise_q) begin
            // Coincident edges: the bit is part of the frame being latched.
            shift_d = shift_in_s;
            if (cnt_inc_s == CNT_FULL) begin
              data_d  = shift_in_s;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            cnt_d   = CNT_ZERO;
            state_d = IDLE;
          end else begin
            shift_d = shift_in_s;
            cnt_d   = cnt_inc_s;
          end
        end else if (slat_rise_q) begin
          if (cnt_q == CNT_FULL) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          cnt_d   = CNT_ZERO;
          tmo_d   = TMO_ZERO;
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          tmo_d   = TMO_ZERO;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        tmo_d   = TMO_ZERO;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Saturating error counter next state
  always_comb begin
    if (err_d && (errcnt_q != 16'hFFFF)) begin
      errcnt_d = errcnt_q + 16'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= CNT_ZERO;
      tmo_q    <= TMO_ZERO;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 16'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      busy_q   <= (state_d == SHIFT);
    end
  end

  assign Data_ob       = data_q;
  assign DataValid_o   = valid_q;
  assign FrameError_o  = err_q;
  assign ErrorCount_ob = errcnt_q;
  assign Busy_o        = busy_q;

endmodule

// File: tb/tb_serial_register_receiver.sv
// Self-checking bench for serial_register_receiver: table of frames plus
// hand-written timeout, mid-frame reset and coincident-edge sequences. A
// scoreboard queue holds the expected DataValid/FrameError events.

module tb_serial_register_receiver;

  logic            clk;
  logic            rst_n;
  ckrs_pkg::ckrs_t clkrs;
  logic            ser_clk;
  logic            ser_data;
  logic            ser_latch;
  logic [31:0]     data_ob;
  logic            data_valid;
  logic            frame_error;
  logic [15:0]     error_count;
  logic            busy;

  assign clkrs = '{clk: clk, reset: rst_n};

  serial_register_receiver #(
    .g_width(32), .g_sync_stages(2), .g_timeout(1000)
  ) dut (
    .ClkRs_ix     (clkrs),
    .SerClk_i     (ser_clk),
    .SerData_i    (ser_data),
    .SerLatch_i   (ser_latch),
    .Data_ob      (data_ob),
    .DataValid_o  (data_valid),
    .FrameError_o (frame_error),
    .ErrorCount_ob(error_count),
    .Busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_valid;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          nbits;
    logic [31:0] word;
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ser_data = b;
    ser_clk  = 1'b0;
    wait_clk(4);
    ser_clk  = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_bits(input int nbits, input logic [31:0] word);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[31 - (i % 32)]);
    end
  endtask

  task automatic send_latch();
    ser_latch = 1'b1;
    wait_clk(4);
    ser_latch = 1'b0;
    wait_clk(4);
  endtask

  task automatic push_exp(input logic is_valid, input logic [31:0] d);
    exp_t e;
    e.is_valid = is_valid;
    e.data     = d;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (data_valid || frame_error)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_event", 64'({data_valid, frame_error}), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("event_kind", 64'({data_valid, frame_error}), 64'({e.is_valid, ~e.is_valid}));
        if (e.is_valid) begin
          chk("event_data", 64'(data_ob), 64'(e.data));
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog: time %0t reached, required finish before 400000", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    vecs[0] = '{32, 32'hA5C30F96, 1'b1, 1'b0, 32'hA5C30F96, 16'd0};
    vecs[1] = '{31, 32'h12345678, 1'b0, 1'b1, 32'hA5C30F96, 16'd1};
    vecs[2] = '{33, 32'h0F0F0F0F, 1'b0, 1'b1, 32'hA5C30F96, 16'd2};
    vecs[3] = '{32, 32'h5A3C96E1, 1'b1, 1'b0, 32'h5A3C96E1, 16'd2};
    vecs[4] = '{0,  32'h00000000, 1'b0, 1'b1, 32'h5A3C96E1, 16'd3};
    vecs[5] = '{32, 32'h0000FFFF, 1'b1, 1'b0, 32'h0000FFFF, 16'd3};

    rst_n     = 1'b0;
    ser_clk   = 1'b0;
    ser_data  = 1'b0;
    ser_latch = 1'b0;
    wait_clk(3);
    chk("reset_outputs", 64'({data_valid, frame_error, busy, error_count, data_ob}), 64'd0);
    rst_n = 1'b1;

    // Idle with quiet lines: everything stays zero
    for (int i = 0; i < 100; i++) begin
      wait_clk(1);
      chk("idle_outputs", 64'({data_valid, frame_error, busy, error_count, data_ob}), 64'd0);
    end

    // Table of whole frames, each followed by a latch
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_valid) push_exp(1'b1, vecs[v].word);
      if (vecs[v].exp_err)   push_exp(1'b0, 32'd0);
      send_bits(vecs[v].nbits, vecs[v].word);
      send_latch();
      wait_clk(8);
      chk("frame_data_ob", 64'(data_ob), 64'(vecs[v].exp_data));
      chk("frame_err_count", 64'(error_count), 64'(vecs[v].exp_cnt));
      chk("frame_busy_idle", 64'(busy), 64'd0);
      chk("frame_events_done", 64'(sb_q.size()), 64'd0);
    end

    // Stall after 10 bits: timeout abort, then a good frame
    push_exp(1'b0, 32'd0);
    send_bits(10, 32'hFFC00000);
    chk("busy_mid_frame", 64'(busy), 64'd1);
    wait_clk(1000);
    wait_clk(20);
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_err_count", 64'(error_count), 64'd4);
    chk("timeout_event_done", 64'(sb_q.size()), 64'd0);
    push_exp(1'b1, 32'h00000001);
    send_bits(32, 32'h00000001);
    send_latch();
    wait_clk(8);
    chk("after_timeout_data", 64'(data_ob), 64'h1);
    chk("after_timeout_events", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a frame: partial frame discarded, no error
    send_bits(16, 32'hABCD1234);
    chk("busy_before_reset", 64'(busy), 64'd1);
    ser_clk = 1'b0;
    rst_n   = 1'b0;
    wait_clk(3);
    rst_n   = 1'b1;
    wait_clk(1);
    chk("midframe_reset_outputs", 64'({data_valid, frame_error, busy, error_count, data_ob}), 64'd0);
    wait_clk(10);
    chk("post_reset_quiet", 64'({data_valid, frame_error, busy, error_count, data_ob}), 64'd0);

    // Coincident shift-clock and latch rise on bit 32, with latency check
    push_exp(1'b1, 32'hFFFFFFFF);
    send_bits(31, 32'hFFFFFFFF);
    ser_data  = 1'b1;
    ser_clk   = 1'b0;
    wait_clk(4);
    ser_clk   = 1'b1;
    ser_latch = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (data_valid) break;
    end
    chk("valid_latency", 64'(lat), 64'd4);
    wait_clk(4);
    ser_latch = 1'b0;
    wait_clk(8);
    chk("coincident_data", 64'(data_ob), 64'hFFFFFFFF);
    chk("coincident_err_count", 64'(error_count), 64'd0);
    chk("final_events_done", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
